rf_write_arbiter: RTL and testbench

Arbitrates the single register-file write port between two writeback requesters (req0 = ALU result, req1 = load data) and keeps a per-register pending-write scoreboard. Requesters hand data over with a valid/ready handshake; the winner drives the register file's WE3/A3/WD3 through one output register stage. The scoreboard tells decode whether a source register still has a write in flight.

---
 rtl/rf_write_arbiter.sv | 135 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//
// Shares the single register-file write port between two writeback
// requesters: req0 carries ALU results and req1 carries load data. The winning
// request is registered once and then drives the register file's WE3/A3/WD3.
// A per-register pending scoreboard tells decode which source registers still
// have a write in flight.
//
// Ports
//   clk                       rising-edge clock for all state
//   reset                     asynchronous, active-low reset
//   req0_*/req1_*             valid/ready write requests (addr, data)
//   rsv_valid, rsv_addr       issue stage reserves a destination register
//   rd_addr1/2, busy1/2       decode source query; busy is combinational
//   rf_we, rf_waddr, rf_wdata registered register-file write port
//   pending                   scoreboard vector, bit i = write to reg i in flight
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [NUM_REGS-1:0]   pending
);

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_e;

  grant_e                last_grant_q, last_grant_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  // Arbitration looks only at the valids and last_grant_q, never at rf_we,
  // so there is no combinational path from the write port back to ready.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (req0_valid && req1_valid) begin
      // Round robin on a tie: the requester that did not win last time.
      if (last_grant_q == GRANT_REQ1) req0_ready = 1'b1;
      else                            req1_ready = 1'b1;
    end else begin
      req0_ready = req0_valid;
      req1_ready = req1_valid;
    end
  end

  // Write-port output stage. Address and data hold when idle; only the
  // enable drops. Writes to register 0 complete the handshake but never
  // raise the enable.
  always_comb begin
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    if (req0_ready) begin
      last_grant_d = GRANT_REQ0;
      rf_we_d      = (req0_addr != '0);
      rf_waddr_d   = req0_addr;
      rf_wdata_d   = req0_data;
    end else if (req1_ready) begin
      last_grant_d = GRANT_REQ1;
      rf_we_d      = (req1_addr != '0);
      rf_waddr_d   = req1_addr;
      rf_wdata_d   = req1_data;
    end
  end

  // Scoreboard: a reservation beats a completing write to the same register,
  // so a newly issued writer is never lost to an older one retiring.
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rsv_valid && (rsv_addr == ADDR_WIDTH'(i))) begin
        pending_d[i] = 1'b1;
      end else if (rf_we_q && (rf_waddr_q == ADDR_WIDTH'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the scoreboard is a plain flop vector, not a RAM, so it is
      // reset along with everything else; a dropped in-flight write must not
      // leave a stale pending bit behind.
      last_grant_q <= GRANT_REQ1;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      pending_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values regardless of statement order.
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      pending_q    <= pending_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign pending  = pending_q;
  assign busy1    = pending_q[rd_addr1];
  assign busy2    = pending_q[rd_addr2];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter. Stimulus is issued at the falling edge; each
// accepted write to a non-zero register pushes its expected {addr, data} into
// a queue, and a monitor pops and compares every cycle the DUT shows rf_we.
module tb_rf_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          rsv_valid;
  logic [AW-1:0] rsv_addr;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic          busy1, busy2;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [NR-1:0] pending;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  wr_t mon_exp;
  int  checks = 0;
  int  errors = 0;

  rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .busy1      (busy1),
    .busy2      (busy2),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the write port is enabled must match the oldest
  // expected write; an enable with nothing expected is an error.
  always @(negedge clk) begin
    if (reset === 1'b1 && rf_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got addr=%0d data=%0h expected no write",
                 rf_waddr, rf_wdata);
      end else begin
        mon_exp = sb_q.pop_front();
        check("wr_addr", 64'(rf_waddr), 64'(mon_exp.addr));
        check("wr_data", 64'(rf_wdata), 64'(mon_exp.data));
      end
    end
  end

  // Called just after a falling edge: apply inputs, check the grant, record
  // the expected write, and return at the next falling edge.
  task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic rv, input logic [AW-1:0] ra,
                      input logic e0, input logic e1, input string tag);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    rsv_valid  = rv; rsv_addr  = ra;
    #1;
    check({tag, "_ready0"}, 64'(req0_ready), 64'(e0));
    check({tag, "_ready1"}, 64'(req1_ready), 64'(e1));
    if (e0 && a0 != '0) sb_q.push_back('{addr: a0, data: d0});
    if (e1 && a1 != '0) sb_q.push_back('{addr: a1, data: d1});
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t expected run to finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random inputs.
    reset = 1'b0;
    repeat (3) begin
      req0_valid = 1'($urandom); req0_addr = AW'($urandom); req0_data = $urandom;
      req1_valid = 1'($urandom); req1_addr = AW'($urandom); req1_data = $urandom;
      rsv_valid  = 1'($urandom); rsv_addr  = AW'($urandom);
      rd_addr1   = AW'($urandom); rd_addr2 = AW'($urandom);
      @(negedge clk);
      #1;
      check("rst_we",    64'(rf_we),    64'(0));
      check("rst_waddr", 64'(rf_waddr), 64'(0));
      check("rst_wdata", 64'(rf_wdata), 64'(0));
      check("rst_pend",  64'(pending),  64'(0));
      check("rst_busy1", 64'(busy1),    64'(0));
    end
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd0;
    idle("pre");
    reset = 1'b1;

    // Contention: first tie goes to req0, then alternates.
    step(1, 5'd3, 32'h30, 1, 5'd4, 32'h40, 0, '0, 1, 0, "cont0");
    step(1, 5'd3, 32'h30, 1, 5'd4, 32'h40, 0, '0, 0, 1, "cont1");
    step(1, 5'd3, 32'h30, 1, 5'd4, 32'h40, 0, '0, 1, 0, "cont2");
    step(1, 5'd3, 32'h30, 1, 5'd4, 32'h40, 0, '0, 0, 1, "cont3");

    // Single requester, then idle so the write shows for exactly one cycle.
    step(0, 5'd0, 32'h0, 1, 5'd7, 32'hDEADBEEF, 0, '0, 0, 1, "single");
    idle("idle0");
    idle("idle1");

    // Register 0: accepted, never written, never pending.
    step(1, 5'd0, 32'h55, 0, '0, '0, 1, 5'd0, 1, 0, "reg0");
    check("reg0_pend0", 64'(pending[0]), 64'(0));
    check("reg0_busy1", 64'(busy1),      64'(0));
    check("reg0_pend",  64'(pending),    64'(0));

    // Scoreboard set/clear on register 9.
    rd_addr1 = 5'd9;
    rd_addr2 = 5'd9;
    step(0, '0, '0, 0, '0, '0, 1, 5'd9, 0, 0, "rsv9");
    check("rsv9_busy1", 64'(busy1), 64'(1));
    check("rsv9_busy2", 64'(busy2), 64'(1));
    step(1, 5'd9, 32'h99, 0, '0, '0, 0, '0, 1, 0, "wr9");
    check("wr9_busy1_n", 64'(busy1), 64'(1));
    idle("wr9_idle");
    check("wr9_busy1_n1", 64'(busy1), 64'(0));
    check("wr9_busy2_n1", 64'(busy2), 64'(0));

    // Reserve and completing write on register 12 in the same cycle.
    step(0, '0, '0, 0, '0, '0, 1, 5'd12, 0, 0, "rsv12");
    check("rsv12_pend", 64'(pending), 64'(32'h0000_1000));
    step(0, '0, '0, 1, 5'd12, 32'hC0C0, 0, '0, 0, 1, "wr12");
    step(0, '0, '0, 0, '0, '0, 1, 5'd12, 0, 0, "rsv12b");
    check("sim12_pend", 64'(pending[12]), 64'(1));
    idle("sim12_idle");
    check("sim12_hold", 64'(pending[12]), 64'(1));

    // Reset mid-operation drops the in-flight write and all state.
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h5555;
    req1_valid = 1'b0; rsv_valid = 1'b1; rsv_addr = 5'd20;
    #1;
    check("mid_ready0", 64'(req0_ready), 64'(1));
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_we",    64'(rf_we),    64'(0));
    check("mid_waddr", 64'(rf_waddr), 64'(0));
    check("mid_wdata", 64'(rf_wdata), 64'(0));
    check("mid_pend",  64'(pending),  64'(0));
    @(negedge clk);
    idle("mid_idle");
    reset = 1'b1;

    // After reset, the first tie goes to req0 again.
    step(1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 0, '0, 1, 0, "post");
    idle("end0");
    idle("end1");
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
